// File: rtl/freq_meter.sv
// Period meter for a slow asynchronous square wave: synchronizes sig_in to clk, counts
// clk cycles between rising edges, flags loss of signal and reports period stability.
module freq_meter #(
    parameter int               CNT_W       = 25,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC = 25'd20000000,
    parameter logic [CNT_W-1:0] TOL         = 25'd4,
    parameter int               LOCK_CNT    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic             locked
);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURING,
        LOST
    } state_t;

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic             prev_ok;
    logic [3:0]       lock_run;
    logic [3:0]       lock_next;
    logic [CNT_W:0]   diff;
    logic             stable;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        diff = '0;
        if (cnt >= period) begin
            diff = {1'b0, cnt} - {1'b0, period};
        end else begin
            diff = {1'b0, period} - {1'b0, cnt};
        end
    end

    assign stable = (diff <= {1'b0, TOL});

    always_comb begin
        lock_next = LOCK_MAX;
        if (lock_run < LOCK_MAX) begin
            lock_next = lock_run + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_FIRST;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            locked       <= 1'b0;
            prev_ok      <= 1'b0;
            lock_run     <= '0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                WAIT_FIRST: begin
                    cnt <= '0;
                    if (rise) begin
                        cnt   <= CNT_W'(1);
                        state <= MEASURING;
                    end
                end
                MEASURING: begin
                    // A rise on the timeout cycle still counts as a valid period.
                    if (rise) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        cnt          <= CNT_W'(1);
                        if (!prev_ok) begin
                            lock_run <= '0;
                            prev_ok  <= 1'b1;
                        end else if (stable) begin
                            lock_run <= lock_next;
                            if (lock_next == LOCK_MAX) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            lock_run <= '0;
                            locked   <= 1'b0;
                        end
                    end else if (cnt == TIMEOUT_CYC) begin
                        timeout  <= 1'b1;
                        locked   <= 1'b0;
                        lock_run <= '0;
                        prev_ok  <= 1'b0;
                        cnt      <= '0;
                        state    <= LOST;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOST: begin
                    cnt <= '0;
                    if (rise) begin
                        timeout <= 1'b0;
                        cnt     <= CNT_W'(1);
                        state   <= MEASURING;
                    end
                end
                default: begin
                    state <= WAIT_FIRST;
                    cnt   <= '0;
                end
            endcase
        end
    end

    a_no_lock_when_lost: assert property (@(posedge clk) disable iff (!rst_n) !(timeout && locked));

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: random and directed edge trains are compared against
// an event-level model built from rise times (periods, lock streaks, timeout windows).
module tb_freq_meter;

    localparam int CNT_W = 25;
    localparam int TMO   = 200;
    localparam int LOCKN = 4;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period, period6;
    logic             period_valid, valid6, timeout, timeout6, locked, locked6;

    freq_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(25'd200), .TOL(25'd4), .LOCK_CNT(LOCKN)) u_dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .period(period),
        .period_valid(period_valid), .timeout(timeout), .locked(locked));

    freq_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(25'd200), .TOL(25'd6), .LOCK_CNT(LOCKN)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .period(period6),
        .period_valid(valid6), .timeout(timeout6), .locked(locked6));

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int per;
        bit lk;
        bit lk6;
    } vev_t;

    typedef struct {
        int cyc;
        bit lvl;
    } tev_t;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    vev_t obs_v[$];
    tev_t obs_t[$];
    int   ra[$];
    int   overlap = 0;
    int   mism6 = 0;
    bit   prev_to = 1'b0;
    vev_t mon_v;
    tev_t mon_t;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: valid strobes, timeout level changes, and cross-instance sanity.
    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            mon_v.cyc = cyc;
            mon_v.per = int'(period);
            mon_v.lk  = locked;
            mon_v.lk6 = locked6;
            obs_v.push_back(mon_v);
        end
        if (timeout !== prev_to) begin
            mon_t.cyc = cyc;
            mon_t.lvl = timeout;
            obs_t.push_back(mon_t);
        end
        prev_to = timeout;
        if (timeout === 1'b1 && locked === 1'b1) overlap++;
        if (period_valid !== valid6 || timeout !== timeout6 || period !== period6) mism6++;
    end

    task automatic apply_reset();
        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        ra.delete();
        obs_v.delete();
        obs_t.delete();
        overlap = 0;
        mism6   = 0;
    endtask

    // Each gap is the distance to the next rise; the last gap is an idle tail.
    task automatic drive(input int gaps[$]);
        int h;
        foreach (gaps[i]) begin
            sig_in = 1'b1;
            ra.push_back(cyc + 3);
            h = gaps[i] / 2;
            repeat (h) @(negedge clk);
            sig_in = 1'b0;
            repeat (gaps[i] - h) @(negedge clk);
        end
    endtask

    task automatic check_model(input string name);
        vev_t ev[$];
        tev_t et[$];
        vev_t v;
        tev_t t;
        int   last = 0, prev = 0, s4 = 0, s6 = 0, p, d, end_c, n;
        bit   fresh = 1'b1, lost = 1'b0, have_prev = 1'b0;
        end_c = cyc;
        foreach (ra[i]) begin
            if (!fresh && ra[i] - last > TMO) begin
                t.cyc = last + TMO; t.lvl = 1'b1; et.push_back(t);
                fresh = 1'b1; lost = 1'b1; have_prev = 1'b0; s4 = 0; s6 = 0;
            end
            if (fresh) begin
                if (lost) begin
                    t.cyc = ra[i]; t.lvl = 1'b0; et.push_back(t);
                    lost = 1'b0;
                end
                fresh = 1'b0;
                last  = ra[i];
            end else begin
                p = ra[i] - last;
                d = (p > prev) ? p - prev : prev - p;
                if (!have_prev) begin
                    have_prev = 1'b1; s4 = 0; s6 = 0;
                end else begin
                    s4 = (d <= 4) ? s4 + 1 : 0;
                    s6 = (d <= 6) ? s6 + 1 : 0;
                end
                v.cyc = ra[i]; v.per = p; v.lk = (s4 >= LOCKN); v.lk6 = (s6 >= LOCKN);
                ev.push_back(v);
                prev = p;
                last = ra[i];
            end
        end
        if (!fresh && end_c >= last + TMO) begin
            t.cyc = last + TMO; t.lvl = 1'b1; et.push_back(t);
        end

        n_checks++;
        if (obs_v.size() !== ev.size()) begin
            n_fail++;
            $display("FAIL %s valid_count: got %0d expected %0d", name, obs_v.size(), ev.size());
        end
        n = (obs_v.size() < ev.size()) ? obs_v.size() : ev.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (obs_v[i].cyc !== ev[i].cyc || obs_v[i].per !== ev[i].per) begin
                n_fail++;
                $display("FAIL %s valid[%0d]: got cyc %0d period %0d expected cyc %0d period %0d",
                         name, i, obs_v[i].cyc, obs_v[i].per, ev[i].cyc, ev[i].per);
            end
            n_checks++;
            if (obs_v[i].lk !== ev[i].lk || obs_v[i].lk6 !== ev[i].lk6) begin
                n_fail++;
                $display("FAIL %s locked[%0d]: got tol4 %0b tol6 %0b expected tol4 %0b tol6 %0b",
                         name, i, obs_v[i].lk, obs_v[i].lk6, ev[i].lk, ev[i].lk6);
            end
        end

        n_checks++;
        if (obs_t.size() !== et.size()) begin
            n_fail++;
            $display("FAIL %s timeout_events: got %0d expected %0d", name, obs_t.size(), et.size());
        end
        n = (obs_t.size() < et.size()) ? obs_t.size() : et.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (obs_t[i].cyc !== et[i].cyc || obs_t[i].lvl !== et[i].lvl) begin
                n_fail++;
                $display("FAIL %s timeout[%0d]: got cyc %0d level %0b expected cyc %0d level %0b",
                         name, i, obs_t[i].cyc, obs_t[i].lvl, et[i].cyc, et[i].lvl);
            end
        end

        n_checks++;
        if (overlap !== 0) begin
            n_fail++;
            $display("FAIL %s timeout_and_locked: got %0d cycles expected 0", name, overlap);
        end
        n_checks++;
        if (mism6 !== 0) begin
            n_fail++;
            $display("FAIL %s instance_agreement: got %0d differing cycles expected 0", name, mism6);
        end
    endtask

    task automatic expect_idle_outputs(input string name);
        n_checks++;
        if (period !== '0 || period_valid !== 1'b0 || timeout !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL %s outputs: got period %0d valid %0b timeout %0b locked %0b expected all 0",
                     name, period, period_valid, timeout, locked);
        end
        n_checks++;
        if (period6 !== '0 || valid6 !== 1'b0 || timeout6 !== 1'b0 || locked6 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s outputs_tol6: got period %0d valid %0b timeout %0b locked %0b expected all 0",
                     name, period6, valid6, timeout6, locked6);
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        expect_idle_outputs("reset_asserted");
        apply_reset();
        repeat (10) @(negedge clk);
        #1;
        expect_idle_outputs("reset_released");
    endtask

    task automatic test_steady();
        int g[$];
        apply_reset();
        for (int i = 0; i < 10; i++) g.push_back(100);
        drive(g);
        check_model("steady_100");
    endtask

    task automatic test_jump();
        int g[$];
        apply_reset();
        for (int i = 0; i < 7; i++) g.push_back(100);
        for (int i = 0; i < 7; i++) g.push_back(120);
        drive(g);
        check_model("jump_120");
    endtask

    task automatic test_timeout();
        int g[$];
        apply_reset();
        g = '{100, 100, 100, 230};
        drive(g);
        #1;
        n_checks++;
        if (timeout !== 1'b1 || locked !== 1'b0 || period !== 25'd100) begin
            n_fail++;
            $display("FAIL timeout_hold: got timeout %0b locked %0b period %0d expected 1 0 100",
                     timeout, locked, period);
        end
        g = '{100, 100, 60};
        drive(g);
        check_model("timeout");
    endtask

    task automatic test_exact_timeout();
        int g[$];
        apply_reset();
        g = '{200, 200, 201, 100, 200, 60};
        drive(g);
        check_model("exact_timeout");
    endtask

    task automatic test_tolerance();
        int g[$];
        apply_reset();
        g = '{100, 103, 97, 101, 100, 60};
        drive(g);
        check_model("tolerance");
        n_checks++;
        if (obs_v.size() !== 5 || locked !== 1'b0 || locked6 !== 1'b1) begin
            n_fail++;
            $display("FAIL tolerance_final: got valids %0d tol4 %0b tol6 %0b expected 5 0 1",
                     obs_v.size(), locked, locked6);
        end
    endtask

    task automatic test_random();
        int g[$];
        int base;
        apply_reset();
        base = 100;
        for (int i = 0; i < 60; i++) begin
            if (i % 8 == 0) base = int'($urandom_range(40, 150));
            if ($urandom_range(0, 11) == 0) g.push_back(int'($urandom_range(195, 215)));
            else g.push_back(base + int'($urandom_range(0, 8)) - 4);
        end
        g.push_back(80);
        drive(g);
        check_model("random");
    endtask

    task automatic test_reset_mid();
        int g[$];
        apply_reset();
        for (int i = 0; i < 7; i++) g.push_back(100);
        g.push_back(30);
        drive(g);
        check_model("pre_reset");
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_locked: got %0b expected 1", locked);
        end
        #2 rst_n = 1'b0;
        #1;
        expect_idle_outputs("reset_mid");
        apply_reset();
        g = '{100, 100, 60};
        drive(g);
        check_model("after_reset");
    endtask

    initial begin
        test_reset();
        test_steady();
        test_jump();
        test_timeout();
        test_exact_timeout();
        test_tolerance();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Receive-side counterpart of the team's clock-divider toggle outputs.
- Takes an asynchronous, slow square wave (`sig_in`, e.g. a divided-clock toggle), synchronizes it to `clk` and measures the rising-edge-to-rising-edge period in `clk` cycles.
- Reports each period with a one-cycle valid strobe, flags loss of signal, and asserts `locked` once the period has been stable for several consecutive measurements.
- Used by the game logic to check that timing ticks are alive and steady.

Parameters:
- CNT_W, 25, width of the period counter and of the `period` output.
- TIMEOUT_CYC, 25'd20000000, cycles without a rising edge before signal loss is declared; must be ≥ 2 and ≤ 2^CNT_W−1.
- TOL, 25'd4, maximum absolute difference between consecutive periods still counted as stable.
- LOCK_CNT, 4, consecutive stable periods required to assert `locked` (1..15).

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- sig_in, input, 1, asynchronous square wave to measure.
- period, output, CNT_W, last measured period in clk cycles.
- period_valid, output, 1, one-cycle strobe: `period` was updated this cycle.
- timeout, output, 1, level: no rising edge within TIMEOUT_CYC cycles.
- locked, output, 1, level: period stable for LOCK_CNT consecutive measurements.

Behaviour:
- Reset values (async on rst_n=0):
  - sync flops s1/s2/s3=0, cnt=0, state=WAIT_FIRST;
  - period=0, period_valid=0, timeout=0, locked=0;
  - prev_ok=0, lock_run=0.
- Synchronizer: s1<=sig_in, s2<=s1, s3<=s2; rise = s2 & ~s3 (combinational, one cycle per edge).
  - If sig_in rises before clock edge E0 and stays high, rise is true between E1 and E2, and period_valid is high after E2.
- FSM states: WAIT_FIRST, MEASURING, LOST.
- WAIT_FIRST:
  - cnt held at 0.
  - On rise: cnt<=1, go to MEASURING; no period reported.
- MEASURING, on rise:
  - period<=cnt, period_valid<=1 for one cycle, cnt<=1.
  - Consequence: edges P cycles apart report P.
- MEASURING, otherwise:
  - If cnt==TIMEOUT_CYC: timeout<=1, locked<=0, lock_run<=0, prev_ok<=0, cnt<=0, go to LOST; period keeps its last value.
  - Else cnt<=cnt+1.
- Simultaneous rise and cnt==TIMEOUT_CYC: rise wins; period=TIMEOUT_CYC is reported; no timeout.
- LOST:
  - cnt held at 0.
  - On rise: timeout<=0, cnt<=1, go to MEASURING; no period reported for this edge.
- Lock tracking, evaluated on every period_valid cycle with new = cnt:
  - If prev_ok=0: lock_run<=0, prev_ok<=1.
  - Else if |new − period| ≤ TOL: lock_run<=min(lock_run+1, LOCK_CNT).
  - Else lock_run<=0, locked<=0.
  - locked<=1 on the cycle lock_run reaches LOCK_CNT; it stays high while subsequent periods remain within TOL.
- Arithmetic:
  - Difference is computed unsigned at CNT_W+1 bits as the larger operand minus the smaller; no wrap.
  - cnt cannot overflow, since timeout fires at TIMEOUT_CYC < 2^CNT_W.
- sig_in glitches shorter than one clk may be missed; this is accepted.
- Reset mid-measurement discards all state; the next rise after release is treated as the first edge.
- timeout and locked are never both 1.

Test Plan:
- Reset, then a square wave of period 100 clk (50 high / 50 low) → first period_valid on the second rising edge, period=100; every later edge reports 100.
- Same 100-cycle wave with TOL=4, LOCK_CNT=4 → locked rises together with the 5th period_valid (4th stable compare); the wave then jumps to period 120 → next valid period=120, locked falls the same cycle, and it re-locks 4 periods later.
- TIMEOUT_CYC=200; sig_in held low after a valid edge → timeout=1 exactly 200 cycles after the cnt=1 cycle, locked=0, period unchanged; the next rise clears timeout with no period_valid; the following edge reports the true period.
- Edge exactly TIMEOUT_CYC cycles after the previous one → period_valid with period=200; timeout stays 0.
- Assert rst_n low mid-period while locked=1 → all outputs 0 immediately (asynchronous); after release the first edge gives no valid strobe and the second edge reports its period.
- Periods of 100, 103, 97, 101, 100 with TOL=4, LOCK_CNT=4 → lock_run resets at the 103→97 step (diff 6), so locked stays 0 throughout; with TOL=6 → locked asserts on the 5th period.
